// File: rtl/dsp48a1_pkg.sv
// Shared constants and types for the dsp48a1_slice codebase.
// Contents:
//   - Datapath widths (pre-adder/B path, multiplier product, post-adder/P).
//   - X and Z operand mux select encodings as enums.
//   - Bit positions of the individual fields inside OPMODE.
package dsp48a1_pkg;

    localparam int AB_W = 18;
    localparam int M_W  = 36;
    localparam int P_W  = 48;

    // X operand select, OPMODE[1:0]
    typedef enum logic [1:0] {
        X_ZERO   = 2'd0,
        X_M      = 2'd1,
        X_P      = 2'd2,
        X_CONCAT = 2'd3
    } x_sel_e;

    // Z operand select, OPMODE[3:2]
    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

    localparam int OP_X_LSB       = 0;
    localparam int OP_Z_LSB       = 2;
    localparam int OP_PREADD_SEL  = 4;
    localparam int OP_CARRYIN     = 5;
    localparam int OP_PREADD_SUB  = 6;
    localparam int OP_POSTADD_SUB = 7;

endpackage

// File: rtl/dsp48a1_pipe_reg.sv
// Optional pipeline register used for every stage of the DSP slice.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset, takes priority over ce
//   ce    - active-high clock enable; low holds the stored value
//   d     - stage input
//   q     - stage output (registered when PRESENT != 0, else d itself)
module dsp_pipe_reg #(
    parameter int WIDTH   = 18,
    parameter int PRESENT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (PRESENT != 0) begin : g_reg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q <= '0;
            end else if (ce) begin
                q <= d;
            end
        end
    end else begin : g_bypass
        // Bypassed stage: clock, reset and enable are deliberately unused.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, ce};
        assign q = d;
    end

endmodule

// File: rtl/dsp48a1_slice.sv
// DSP48A1-style arithmetic slice: 18-bit pre-adder, 18x18 unsigned multiplier,
// 48-bit post-adder with X/Z operand muxes, carry-in select and carry-out.
// Each stage has an optional register (parameters *REG) with its own CE and
// synchronous active-low reset.
// Optional feature: define DSP_PCIN_CASCADE_EN to route PCIN on Z select 1;
// without it Z select 1 gives 0 and PCIN is ignored.
// Ports:
//   CLK                          - clock
//   RST{A,B,C,D,M,P,CARRYIN,OPMODE} - sync active-low resets per stage
//   CE{A,B,C,D,M,P,CARRYIN,OPMODE}  - active-high clock enables per stage
//   A, B, D, BCIN [17:0]         - operands and B cascade input
//   C, PCIN [47:0]               - post-adder operand and P cascade input
//   CARRYIN                      - external carry-in
//   OPMODE [7:0]                 - operation control
//   BCOUT [17:0]                 - B1 stage output
//   M [35:0]                     - multiplier stage output
//   P, PCOUT [47:0]              - result and cascade copy
//   CARRYOUT, CARRYOUTF          - carry-out and fabric copy
module dsp48a1_slice
    import dsp48a1_pkg::*;
#(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic            CLK,
    input  logic            RSTA,
    input  logic            RSTB,
    input  logic            RSTC,
    input  logic            RSTD,
    input  logic            RSTM,
    input  logic            RSTP,
    input  logic            RSTCARRYIN,
    input  logic            RSTOPMODE,
    input  logic            CEA,
    input  logic            CEB,
    input  logic            CEC,
    input  logic            CED,
    input  logic            CEM,
    input  logic            CEP,
    input  logic            CECARRYIN,
    input  logic            CEOPMODE,
    input  logic [AB_W-1:0] A,
    input  logic [AB_W-1:0] B,
    input  logic [AB_W-1:0] D,
    input  logic [AB_W-1:0] BCIN,
    input  logic [P_W-1:0]  C,
    input  logic [P_W-1:0]  PCIN,
    input  logic            CARRYIN,
    input  logic [7:0]      OPMODE,
    output logic [AB_W-1:0] BCOUT,
    output logic [M_W-1:0]  M,
    output logic [P_W-1:0]  P,
    output logic [P_W-1:0]  PCOUT,
    output logic            CARRYOUT,
    output logic            CARRYOUTF
);

    // Unrecognised string values fall back to DIRECT / OPMODE5.
    localparam bit B_FROM_CASCADE = (B_INPUT == "CASCADE");
    localparam bit CIN_FROM_PORT  = (CARRYINSEL == "CARRYIN");

    logic [7:0]      opmode_r;
    logic [AB_W-1:0] a0, a1, b0, b1, d_r, b_src, pre_sum, b1_in;
    logic [P_W-1:0]  c_r, p_r, x_mux, z_mux;
    logic [M_W-1:0]  m_prod, m_r;
    logic            cin_src, cin_r, co_r;
    logic [P_W:0]    post_sum;
    x_sel_e          x_sel;
    z_sel_e          z_sel;

    dsp_pipe_reg #(.WIDTH(8), .PRESENT(OPMODEREG)) u_opmode (
        .clk(CLK), .rst_n(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(opmode_r));

    dsp_pipe_reg #(.WIDTH(AB_W), .PRESENT(A0REG)) u_a0 (
        .clk(CLK), .rst_n(RSTA), .ce(CEA), .d(A), .q(a0));
    dsp_pipe_reg #(.WIDTH(AB_W), .PRESENT(A1REG)) u_a1 (
        .clk(CLK), .rst_n(RSTA), .ce(CEA), .d(a0), .q(a1));

    assign b_src = B_FROM_CASCADE ? BCIN : B;

    dsp_pipe_reg #(.WIDTH(AB_W), .PRESENT(B0REG)) u_b0 (
        .clk(CLK), .rst_n(RSTB), .ce(CEB), .d(b_src), .q(b0));
    dsp_pipe_reg #(.WIDTH(AB_W), .PRESENT(DREG)) u_d (
        .clk(CLK), .rst_n(RSTD), .ce(CED), .d(D), .q(d_r));

    // Pre-adder result wraps at 18 bits; it only reaches B1 when selected.
    assign pre_sum = opmode_r[OP_PREADD_SUB] ? (d_r - b0) : (d_r + b0);
    assign b1_in   = opmode_r[OP_PREADD_SEL] ? pre_sum : b0;

    dsp_pipe_reg #(.WIDTH(AB_W), .PRESENT(B1REG)) u_b1 (
        .clk(CLK), .rst_n(RSTB), .ce(CEB), .d(b1_in), .q(b1));

    assign m_prod = M_W'(a1) * M_W'(b1);

    dsp_pipe_reg #(.WIDTH(M_W), .PRESENT(MREG)) u_m (
        .clk(CLK), .rst_n(RSTM), .ce(CEM), .d(m_prod), .q(m_r));
    dsp_pipe_reg #(.WIDTH(P_W), .PRESENT(CREG)) u_c (
        .clk(CLK), .rst_n(RSTC), .ce(CEC), .d(C), .q(c_r));

    assign cin_src = CIN_FROM_PORT ? CARRYIN : opmode_r[OP_CARRYIN];

    dsp_pipe_reg #(.WIDTH(1), .PRESENT(CARRYINREG)) u_cin (
        .clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .d(cin_src), .q(cin_r));

    assign x_sel = x_sel_e'(opmode_r[OP_X_LSB +: 2]);
    assign z_sel = z_sel_e'(opmode_r[OP_Z_LSB +: 2]);

`ifndef DSP_PCIN_CASCADE_EN
    logic unused_pcin;
    assign unused_pcin = ^PCIN;
`endif

    // Operand muxes; the P selections feed back the current P register.
    always_comb begin
        x_mux = '0;
        z_mux = '0;
        case (x_sel)
            X_ZERO:   x_mux = '0;
            X_M:      x_mux = {{(P_W-M_W){1'b0}}, m_r};
            X_P:      x_mux = p_r;
            X_CONCAT: x_mux = {d_r[11:0], a1, b1};
            default:  x_mux = '0;
        endcase
        case (z_sel)
            Z_ZERO:  z_mux = '0;
`ifdef DSP_PCIN_CASCADE_EN
            Z_PCIN:  z_mux = PCIN;
`else
            Z_PCIN:  z_mux = '0;
`endif
            Z_P:     z_mux = p_r;
            Z_C:     z_mux = c_r;
            default: z_mux = '0;
        endcase
    end

    // 49-bit post-adder: bit 48 is carry on add and borrow on subtract.
    always_comb begin
        post_sum = '0;
        if (opmode_r[OP_POSTADD_SUB]) begin
            post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin_r});
        end else begin
            post_sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin_r};
        end
    end

    dsp_pipe_reg #(.WIDTH(P_W), .PRESENT(PREG)) u_p (
        .clk(CLK), .rst_n(RSTP), .ce(CEP), .d(post_sum[P_W-1:0]), .q(p_r));
    dsp_pipe_reg #(.WIDTH(1), .PRESENT(CARRYOUTREG)) u_cout (
        .clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .d(post_sum[P_W]), .q(co_r));

    assign BCOUT     = b1;
    assign M         = m_r;
    assign P         = p_r;
    assign PCOUT     = p_r;
    assign CARRYOUT  = co_r;
    assign CARRYOUTF = co_r;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Self-checking bench for dsp48a1_slice: directed cases plus randomized
// settle-and-compare against an arithmetic reference model. Two instances
// share the inputs: one with B_INPUT="DIRECT", one with B_INPUT="CASCADE".
module tb_dsp48a1_slice;

    logic        clk = 1'b0;
    logic        rst_n, rst_p, ce;
    logic [17:0] a, b, d, bcin;
    logic [47:0] c, pcin;
    logic        cin;
    logic [7:0]  op;

    logic [17:0] bcout, bcout_c;
    logic [35:0] m, m_c;
    logic [47:0] p, p_c, pcout, pcout_c;
    logic        co, co_c, cof, cof_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dsp48a1_slice dut (
        .CLK(clk), .RSTA(rst_n), .RSTB(rst_n), .RSTC(rst_n), .RSTD(rst_n),
        .RSTM(rst_n), .RSTP(rst_n & rst_p), .RSTCARRYIN(rst_n), .RSTOPMODE(rst_n),
        .CEA(ce), .CEB(ce), .CEC(ce), .CED(ce), .CEM(ce), .CEP(ce),
        .CECARRYIN(ce), .CEOPMODE(ce),
        .A(a), .B(b), .D(d), .BCIN(bcin), .C(c), .PCIN(pcin), .CARRYIN(cin),
        .OPMODE(op), .BCOUT(bcout), .M(m), .P(p), .PCOUT(pcout),
        .CARRYOUT(co), .CARRYOUTF(cof));

    dsp48a1_slice #(.B_INPUT("CASCADE")) dut_c (
        .CLK(clk), .RSTA(rst_n), .RSTB(rst_n), .RSTC(rst_n), .RSTD(rst_n),
        .RSTM(rst_n), .RSTP(rst_n & rst_p), .RSTCARRYIN(rst_n), .RSTOPMODE(rst_n),
        .CEA(ce), .CEB(ce), .CEC(ce), .CED(ce), .CEM(ce), .CEP(ce),
        .CECARRYIN(ce), .CEOPMODE(ce),
        .A(a), .B(b), .D(d), .BCIN(bcin), .C(c), .PCIN(pcin), .CARRYIN(cin),
        .OPMODE(op), .BCOUT(bcout_c), .M(m_c), .P(p_c), .PCOUT(pcout_c),
        .CARRYOUT(co_c), .CARRYOUTF(cof_c));

    typedef struct {
        logic [47:0] p;
        logic [35:0] m;
        logic [17:0] bcout;
        logic        co;
    } exp_t;

    // Steady-state result for held inputs (X and Z never select P here).
    function automatic exp_t ref_model(input bit cascade);
        exp_t            e;
        logic [17:0]     b0, pre, b1;
        longint unsigned x, z, cv, total;
        b0  = cascade ? bcin : b;
        pre = op[6] ? (d - b0) : (d + b0);
        b1  = op[4] ? pre : b0;
        e.bcout = b1;
        e.m = 36'(longint'(a) * longint'(b1));
        case (op[1:0])
            2'd1:    x = longint'(e.m);
            2'd3:    x = (longint'(d[11:0]) << 36) | (longint'(a) << 18) | longint'(b1);
            default: x = 0;
        endcase
        case (op[3:2])
`ifdef DSP_PCIN_CASCADE_EN
            2'd1:    z = longint'(pcin);
`endif
            2'd3:    z = longint'(c);
            default: z = 0;
        endcase
        cv = longint'(op[5]);
        if (!op[7]) begin
            total = z + x + cv;
            e.p   = total[47:0];
            e.co  = total[48];
        end else begin
            total = z - x - cv;
            e.p   = total[47:0];
            e.co  = (z < x + cv);
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] op_v, input logic [17:0] a_v,
                                 input logic [17:0] b_v, input logic [17:0] d_v,
                                 input logic [47:0] c_v, input int settle);
        op = op_v; a = a_v; b = b_v; d = d_v; c = c_v;
        tick(settle);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; rst_p = 1'b1; ce = 1'b1;
        a = 18'd77; b = 18'd33; d = 18'd5; bcin = 18'd9; c = 48'd1234;
        pcin = 48'd55; cin = 1'b1; op = 8'hFD;
        tick(5);
        checkOutput("rst_p", p, 0);
        checkOutput("rst_m", m, 0);
        checkOutput("rst_bcout", bcout, 0);
        checkOutput("rst_co", co, 0);
        checkOutput("rst_pcout", pcout, 0);
        checkOutput("rst_cof", cof, 0);
        checkOutput("rst_p_casc", p_c, 0);

        // Multiply-add with latency: P holds only C after two edges.
        op = 8'h0D; a = 18'd15; b = 18'd10; c = 48'd100; d = 18'd0;
        rst_n = 1'b1;
        tick(2);
        checkOutput("madd_p_at2", p, 100);
        checkOutput("madd_m", m, 150);
        tick(1);
        checkOutput("madd_p_at3", p, 250);
        applyStimulus(8'h2D, 18'd15, 18'd10, 18'd0, 48'd100, 5);
        checkOutput("madd_cin", p, 251);
        applyStimulus(8'h8D, 18'd15, 18'd10, 18'd0, 48'd1000, 5);
        checkOutput("msub", p, 850);

        // Clock enables low: everything holds despite new inputs.
        ce = 1'b0;
        applyStimulus(8'h03, 18'd99, 18'd88, 18'd7, 48'd5, 4);
        checkOutput("hold_p", p, 850);
        checkOutput("hold_m", m, 150);
        checkOutput("hold_bcout", bcout, 10);
        ce = 1'b1;

        applyStimulus(8'h1D, 18'd2, 18'd50, 18'd100, 48'd10, 6);
        checkOutput("preadd_bcout", bcout, 150);
        checkOutput("preadd_p", p, 310);
        applyStimulus(8'h5D, 18'd2, 18'd50, 18'd100, 48'd10, 6);
        checkOutput("presub_bcout", bcout, 50);
        checkOutput("presub_p", p, 110);

        applyStimulus(8'h03, 18'd1, 18'd2, 18'd0, 48'd0, 6);
        checkOutput("concat_p", p, 262146);

        applyStimulus(8'h0D, 18'd1, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 6);
        checkOutput("carry_p", p, 0);
        checkOutput("carry_co", co, 1);
        checkOutput("carry_cof", cof, 1);

        bcin = 18'd7; pcin = 48'd40;
        applyStimulus(8'h0D, 18'd3, 18'd9, 18'd0, 48'd0, 6);
        checkOutput("casc_p", p_c, 21);
        checkOutput("casc_bcout", bcout_c, 7);
        checkOutput("casc_direct_p", p, 27);
        applyStimulus(8'h05, 18'd3, 18'd9, 18'd0, 48'd0, 6);
`ifdef DSP_PCIN_CASCADE_EN
        checkOutput("pcin_p", p_c, 61);
`else
        checkOutput("pcin_p", p_c, 21);
`endif

        // Only the P reset asserted: P clears while M keeps its product.
        applyStimulus(8'h0D, 18'd4, 18'd5, 18'd0, 48'd0, 6);
        rst_p = 1'b0;
        tick(2);
        checkOutput("rstp_p", p, 0);
        checkOutput("rstp_m", m, 20);
        rst_p = 1'b1;

        // Accumulate from a clean reset: P = 6*(k-2) after k edges.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        op = 8'h09; a = 18'd2; b = 18'd3;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            checkOutput($sformatf("accum_%0d", k), p, (k < 2) ? 0 : 6 * (k - 2));
        end

        // Randomized settle-and-compare, X/Z never selecting P.
        for (int i = 0; i < 25; i++) begin
            int xs, zs;
            xs = $urandom_range(0, 2); if (xs == 2) xs = 3;
            zs = $urandom_range(0, 2); if (zs == 2) zs = 3;
            op   = 8'($urandom_range(0, 15) << 4) | 8'(zs << 2) | 8'(xs);
            a    = 18'($urandom); b = 18'($urandom); d = 18'($urandom);
            bcin = 18'($urandom);
            c    = {16'($urandom), 32'($urandom)};
            pcin = {16'($urandom), 32'($urandom)};
            cin  = 1'($urandom);
            tick(6);
            e = ref_model(1'b0);
            checkOutput($sformatf("rnd%0d_p", i), p, e.p);
            checkOutput($sformatf("rnd%0d_m", i), m, e.m);
            checkOutput($sformatf("rnd%0d_bcout", i), bcout, e.bcout);
            checkOutput($sformatf("rnd%0d_co", i), co, e.co);
            e = ref_model(1'b1);
            checkOutput($sformatf("rnd%0d_pc", i), p_c, e.p);
            checkOutput($sformatf("rnd%0d_coc", i), co_c, e.co);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
